// File: rtl/riscv_run_pkg.sv
// Shared types for the run controller: state encoding, exit causes and default tohost address.
package riscv_run_pkg;

   typedef logic [1:0] run_state_t;
   localparam run_state_t IDLE  = 2'd0;
   localparam run_state_t RESET = 2'd1;
   localparam run_state_t RUN   = 2'd2;
   localparam run_state_t DONE  = 2'd3;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      TOHOST  = 2'd1,
      SUSPEND = 2'd2,
      TIMEOUT = 2'd3
   } run_cause_t;

   localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_0100;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Host/core-facing signal bundle of the run controller.
interface core_run_ctrl_if;
   import riscv_run_pkg::*;

   logic        start;
   logic        abort;
   logic        suspend;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        core_reset;
   logic        core_en;
   logic        done;
   logic        pass;
   run_cause_t  cause;
   logic [31:0] result;
   logic [31:0] cycle_count;

   modport slave (
      input  start, abort, suspend, memwrite, dataadr, writedata,
      output core_reset, core_en, done, pass, cause, result, cycle_count
   );

   modport master (
      output start, abort, suspend, memwrite, dataadr, writedata,
      input  core_reset, core_en, done, pass, cause, result, cycle_count
   );

endinterface

// File: rtl/core_run_ctrl.sv
// Sequences the core through reset, run and halt; latches exit cause, result and cycle count.
module core_run_ctrl
   import riscv_run_pkg::*;
#(
   parameter int unsigned MAX_CYCLES   = 100000,
   parameter int unsigned RESET_CYCLES = 4,
   parameter logic [31:0] TOHOST_ADDR  = DEFAULT_TOHOST_ADDR
) (
   input  logic            clk,
   input  logic            areset,
   core_run_ctrl_if.slave  bus
);

   run_state_t  r_state,       w_state;
   logic [31:0] r_rst_cnt,     w_rst_cnt;
   logic        r_done,        w_done;
   logic        r_pass,        w_pass;
   run_cause_t  r_cause,       w_cause;
   logic [31:0] r_result,      w_result;
   logic [31:0] r_cycle_count, w_cycle_count;

   logic w_tohost;
   logic w_timeout;
   logic w_clear;

   assign w_tohost  = bus.memwrite && (bus.dataadr == TOHOST_ADDR);
   assign w_timeout = (r_cycle_count == 32'(MAX_CYCLES - 1));
   // Status is wiped on abort and on any honoured start (IDLE or DONE).
   assign w_clear   = bus.abort || (bus.start && ((r_state == IDLE) || (r_state == DONE)));

   always_comb begin
      w_state       = r_state;
      w_rst_cnt     = r_rst_cnt;
      w_done        = r_done;
      w_pass        = r_pass;
      w_cause       = r_cause;
      w_result      = r_result;
      w_cycle_count = r_cycle_count;

      if (w_clear) begin
         w_done        = 1'b0;
         w_pass        = 1'b0;
         w_cause       = NONE;
         w_result      = '0;
         w_cycle_count = '0;
      end

      if (bus.abort) begin
         w_state   = IDLE;
         w_rst_cnt = '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  w_state   = RESET;
                  w_rst_cnt = 32'(RESET_CYCLES - 1);
               end
            end
            RESET: begin
               if (r_rst_cnt == '0) w_state = RUN;
               else                 w_rst_cnt = r_rst_cnt - 32'd1;
            end
            RUN: begin
               w_cycle_count = r_cycle_count + 32'd1;
               if (w_tohost) begin
                  w_state  = DONE;
                  w_done   = 1'b1;
                  w_cause  = TOHOST;
                  w_result = bus.writedata;
                  w_pass   = (bus.writedata == 32'd1);
               end else if (bus.suspend) begin
                  w_state  = DONE;
                  w_done   = 1'b1;
                  w_cause  = SUSPEND;
                  w_pass   = 1'b1;
                  w_result = '0;
               end else if (w_timeout) begin
                  w_state  = DONE;
                  w_done   = 1'b1;
                  w_cause  = TIMEOUT;
                  w_pass   = 1'b0;
               end
            end
            default: w_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         r_state       <= IDLE;
         r_rst_cnt     <= '0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_cause       <= NONE;
         r_result      <= '0;
         r_cycle_count <= '0;
      end else begin
         r_state       <= w_state;
         r_rst_cnt     <= w_rst_cnt;
         r_done        <= w_done;
         r_pass        <= w_pass;
         r_cause       <= w_cause;
         r_result      <= w_result;
         r_cycle_count <= w_cycle_count;
      end
   end

   // Core controls decode the state register only, never inputs.
   assign bus.core_reset  = (r_state == IDLE) || (r_state == RESET);
   assign bus.core_en     = (r_state == RUN);
   assign bus.done        = r_done;
   assign bus.pass        = r_pass;
   assign bus.cause       = r_cause;
   assign bus.result      = r_result;
   assign bus.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: default instance plus a short-timeout instance.
module tb_core_run_ctrl;
   import riscv_run_pkg::*;

   localparam int R = 4;

   typedef struct packed {
      run_cause_t  cause;
      logic        pass;
      logic [31:0] result;
      logic [31:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic areset;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   core_run_ctrl_if bus ();
   core_run_ctrl_if bus_to ();

   core_run_ctrl dut (
      .clk    (clk),
      .areset (areset),
      .bus    (bus)
   );

   core_run_ctrl #(
      .MAX_CYCLES (16)
   ) dut_to (
      .clk    (clk),
      .areset (areset),
      .bus    (bus_to)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (R) tick();
   endtask

   task automatic test_reset();
      exp_t obs;
      areset = 1'b1;
      repeat (3) tick();
      obs = {bus.cause, bus.pass, bus.result, bus.cycle_count};
      n_cmp++;
      if (obs !== exp_t'({NONE, 1'b0, 32'd0, 32'd0})) begin
         n_err++;
         $display("FAIL reset_fields: got %h want 0", obs);
      end
      n_cmp++;
      if ({bus.core_reset, bus.core_en, bus.done} !== 3'b100) begin
         n_err++;
         $display("FAIL reset_ctrl: got rst/en/done=%b want 100",
                  {bus.core_reset, bus.core_en, bus.done});
      end
      areset = 1'b0;
      tick();
   endtask

   task automatic test_start_seq();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < R; i++) begin
         n_cmp++;
         if ({bus.core_reset, bus.core_en} !== 2'b10) begin
            n_err++;
            $display("FAIL start_reset_cyc%0d: got rst/en=%b want 10", i,
                     {bus.core_reset, bus.core_en});
         end
         tick();
      end
      n_cmp++;
      if ({bus.core_reset, bus.core_en, bus.cycle_count} !== {2'b01, 32'd0}) begin
         n_err++;
         $display("FAIL start_run_entry: got rst/en=%b cnt=%0d want 01 cnt=0",
                  {bus.core_reset, bus.core_en}, bus.cycle_count);
      end
      tick();
      n_cmp++;
      if (bus.cycle_count !== 32'd1) begin
         n_err++;
         $display("FAIL start_count_one: got %0d want 1", bus.cycle_count);
      end
   endtask

   task automatic test_tohost();
      exp_t exp, obs;
      int   w;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      start_run();
      repeat (9) tick();
      bus.memwrite  = 1'b1;
      bus.dataadr   = 32'h100;
      bus.writedata = 32'h1;
      exp_q.push_back({TOHOST, 1'b1, 32'h1, 32'd10});
      tick();
      bus.memwrite = 1'b0;
      w = 0;
      while (!bus.done && w < 50) begin
         tick();
         w++;
      end
      n_cmp++;
      if (w !== 0 || exp_q.size() == 0) begin
         n_err++;
         $display("FAIL tohost_latency: got %0d extra cycles want 0", w);
      end else begin
         exp = exp_q.pop_front();
         obs = {bus.cause, bus.pass, bus.result, bus.cycle_count};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL tohost_fields: got %h want %h", obs, exp);
         end
      end
      n_cmp++;
      if (bus.core_en !== 1'b0) begin
         n_err++;
         $display("FAIL tohost_core_en: got %b want 0", bus.core_en);
      end
   endtask

   task automatic test_priority();
      exp_t exp, obs;
      int   w;
      start_run();
      repeat (2) tick();
      bus.memwrite  = 1'b1;
      bus.dataadr   = 32'h104;
      bus.writedata = 32'h2A;
      tick();
      bus.memwrite = 1'b0;
      n_cmp++;
      if ({bus.done, bus.core_en, bus.cycle_count} !== {2'b01, 32'd3}) begin
         n_err++;
         $display("FAIL other_addr_ignored: got done/en=%b cnt=%0d want 01 cnt=3",
                  {bus.done, bus.core_en}, bus.cycle_count);
      end
      bus.memwrite = 1'b1;
      bus.dataadr  = 32'h100;
      bus.suspend  = 1'b1;
      exp_q.push_back({TOHOST, 1'b0, 32'h2A, 32'd4});
      tick();
      bus.memwrite = 1'b0;
      bus.suspend  = 1'b0;
      w = 0;
      while (!bus.done && w < 50) begin
         tick();
         w++;
      end
      n_cmp++;
      if (w !== 0 || exp_q.size() == 0) begin
         n_err++;
         $display("FAIL priority_latency: got %0d extra cycles want 0", w);
      end else begin
         exp = exp_q.pop_front();
         obs = {bus.cause, bus.pass, bus.result, bus.cycle_count};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL priority_fields: got %h want %h", obs, exp);
         end
      end
   endtask

   task automatic test_timeout();
      exp_t exp, obs;
      int   w;
      bus_to.start = 1'b1;
      exp_q.push_back({TIMEOUT, 1'b0, 32'd0, 32'd16});
      tick();
      bus_to.start = 1'b0;
      w = 0;
      while (!bus_to.done && w < 60) begin
         tick();
         w++;
      end
      n_cmp++;
      if (w !== R + 16 || exp_q.size() == 0) begin
         n_err++;
         $display("FAIL timeout_latency: got %0d cycles want %0d", w, R + 16);
      end else begin
         exp = exp_q.pop_front();
         obs = {bus_to.cause, bus_to.pass, bus_to.result, bus_to.cycle_count};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL timeout_fields: got %h want %h", obs, exp);
         end
      end
      n_cmp++;
      if (bus_to.core_en !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_core_en: got %b want 0", bus_to.core_en);
      end
   endtask

   task automatic test_suspend_restart();
      exp_t exp, obs;
      int   w;
      start_run();
      repeat (4) tick();
      bus.suspend = 1'b1;
      exp_q.push_back({SUSPEND, 1'b1, 32'd0, 32'd5});
      tick();
      bus.suspend = 1'b0;
      w = 0;
      while (!bus.done && w < 50) begin
         tick();
         w++;
      end
      n_cmp++;
      if (w !== 0 || exp_q.size() == 0) begin
         n_err++;
         $display("FAIL suspend_latency: got %0d extra cycles want 0", w);
      end else begin
         exp = exp_q.pop_front();
         obs = {bus.cause, bus.pass, bus.result, bus.cycle_count};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL suspend_fields: got %h want %h", obs, exp);
         end
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      obs = {bus.cause, bus.pass, bus.result, bus.cycle_count};
      n_cmp++;
      if (obs !== exp_t'({NONE, 1'b0, 32'd0, 32'd0}) || bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL restart_cleared: got %h done=%b want 0 done=0", obs, bus.done);
      end
      for (int i = 0; i < R; i++) begin
         n_cmp++;
         if ({bus.core_reset, bus.core_en} !== 2'b10) begin
            n_err++;
            $display("FAIL restart_reset_cyc%0d: got rst/en=%b want 10", i,
                     {bus.core_reset, bus.core_en});
         end
         tick();
      end
      n_cmp++;
      if (bus.core_en !== 1'b1) begin
         n_err++;
         $display("FAIL restart_run: got en=%b want 1", bus.core_en);
      end
   endtask

   task automatic test_start_abort();
      bus.suspend = 1'b1;
      tick();
      bus.suspend = 1'b0;
      n_cmp++;
      if (bus.done !== 1'b1) begin
         n_err++;
         $display("FAIL sa_reach_done: got done=%b want 1", bus.done);
      end
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      n_cmp++;
      if ({bus.done, bus.core_reset, bus.cause, bus.cycle_count} !== {2'b01, NONE, 32'd0}) begin
         n_err++;
         $display("FAIL sa_idle: got done=%b rst=%b cause=%0d cnt=%0d want 0 1 0 0",
                  bus.done, bus.core_reset, bus.cause, bus.cycle_count);
      end
      repeat (R + 2) tick();
      n_cmp++;
      if ({bus.core_reset, bus.core_en} !== 2'b10) begin
         n_err++;
         $display("FAIL sa_stays_idle: got rst/en=%b want 10", {bus.core_reset, bus.core_en});
      end
   endtask

   task automatic test_areset_midrun();
      exp_t obs;
      start_run();
      repeat (3) tick();
      areset = 1'b1;
      tick();
      areset = 1'b0;
      obs = {bus.cause, bus.pass, bus.result, bus.cycle_count};
      n_cmp++;
      if (obs !== exp_t'({NONE, 1'b0, 32'd0, 32'd0}) ||
          {bus.core_reset, bus.core_en, bus.done} !== 3'b100) begin
         n_err++;
         $display("FAIL areset_midrun: got %h rst/en/done=%b want 0 100", obs,
                  {bus.core_reset, bus.core_en, bus.done});
      end
   endtask

   task automatic test_abort_reset();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      n_cmp++;
      if ({bus.core_reset, bus.core_en} !== 2'b10) begin
         n_err++;
         $display("FAIL abort_in_reset: got rst/en=%b want 10", {bus.core_reset, bus.core_en});
      end
      repeat (R + 2) tick();
      n_cmp++;
      if (bus.core_en !== 1'b0) begin
         n_err++;
         $display("FAIL abort_no_run: got en=%b want 0", bus.core_en);
      end
   endtask

   initial begin
      areset           = 1'b1;
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.suspend      = 1'b0;
      bus.memwrite     = 1'b0;
      bus.dataadr      = '0;
      bus.writedata    = '0;
      bus_to.start     = 1'b0;
      bus_to.abort     = 1'b0;
      bus_to.suspend   = 1'b0;
      bus_to.memwrite  = 1'b0;
      bus_to.dataadr   = '0;
      bus_to.writedata = '0;

      test_reset();
      test_start_seq();
      test_tohost();
      test_priority();
      test_timeout();
      test_suspend_restart();
      test_start_abort();
      test_areset_midrun();
      test_abort_reset();

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
